// File: rtl/spu_pkg.sv
// spu_pkg: shared definitions for the SPU control sequencer.
//   - bus/register widths and instruction field positions (III_XXX_YYY)
//   - opcode constants, ALU operation codes, sequencer state enum
//   - alu_op_of(): maps an ALU-class opcode to its ALU_OP code
// Optional feature macro used by the sequencer: SPU_CTRL_AND_EN.
package spu_pkg;

  localparam int DW   = 9;
  localparam int NREG = 8;

  // Instruction field slice positions.
  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 6;
  localparam int X_MSB   = 5;
  localparam int X_LSB   = 3;
  localparam int Y_MSB   = 2;
  localparam int Y_LSB   = 0;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  // 2'b11 is reserved and never produced.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // Only called for opcodes that reach T2, so OP_AND only maps to ALU_AND
  // when the AND sequence is enabled.
  function automatic logic [1:0] alu_op_of(input logic [2:0] opc);
    case (opc)
      OP_SUB:  alu_op_of = ALU_SUB;
      OP_AND:  alu_op_of = ALU_AND;
      default: alu_op_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/spu_ctrl_fsm_if.sv
// spu_ctrl_fsm_if: instruction-side request and datapath control strobes.
//   Request (from instruction source): RUN, INSTR
//   Controls (from sequencer): IR_IN, R_IN, R_OUT, DIN_OUT, G_OUT, A_IN,
//   G_IN, ALU_OP, DONE, BUSY
// Handshake: RUN is a start request that is only looked at while the
// sequencer is idle (T0). IR_IN=1 in a cycle is the acceptance of that
// request: INSTR is captured at the end of that same cycle. RUN is ignored
// in every other state; DONE marks the last cycle of the accepted
// instruction, and with RUN still high the next cycle accepts again.
// Modports: slave = sequencer, master = instruction source / observer.
interface spu_ctrl_fsm_if;

  logic                      RUN;
  logic [spu_pkg::DW-1:0]    INSTR;
  logic                      IR_IN;
  logic [spu_pkg::NREG-1:0]  R_IN;
  logic [spu_pkg::NREG-1:0]  R_OUT;
  logic                      DIN_OUT;
  logic                      G_OUT;
  logic                      A_IN;
  logic                      G_IN;
  logic [1:0]                ALU_OP;
  logic                      DONE;
  logic                      BUSY;

  modport slave (
    input  RUN, INSTR,
    output IR_IN, R_IN, R_OUT, DIN_OUT, G_OUT, A_IN, G_IN, ALU_OP, DONE, BUSY
  );

  modport master (
    output RUN, INSTR,
    input  IR_IN, R_IN, R_OUT, DIN_OUT, G_OUT, A_IN, G_IN, ALU_OP, DONE, BUSY
  );

endinterface

// File: rtl/DECODER3x8.sv
// DECODER3x8: 3-to-8 one-hot decoder with enable.
//   W  in  3  select
//   EN in  1  enable; Y is all zero when low
//   Y  out 8  one-hot output, bit W set when EN=1
module DECODER3x8 (
  input  logic [2:0] W,
  input  logic       EN,
  output logic [7:0] Y
);

  always_comb begin
    Y = 8'b0;
    if (EN) Y[W] = 1'b1;
  end

endmodule

// File: rtl/spu_ctrl_fsm.sv
// spu_ctrl_fsm: control sequencer of the simple processor unit.
// Fetches a 9-bit instruction III_XXX_YYY in T0 and steps the datapath
// through T1..T3, driving register enables/selects, bus source and ALU
// controls.
//   CLK       in   rising-edge clock
//   RESETN    in   asynchronous active-low reset; also forces outputs to 0
//   bus       slave modport of spu_ctrl_fsm_if (RUN/INSTR in, controls out)
//   dbg_state out  current sequencer state
// Optional feature macro: SPU_CTRL_AND_EN -- when defined, opcode 100 runs
// the ALU sequence as AND; otherwise it is a 2-cycle nop.
module spu_ctrl_fsm
  import spu_pkg::*;
(
  input  logic               CLK,
  input  logic               RESETN,
  spu_ctrl_fsm_if.slave      bus,
  output state_t             dbg_state
);

  state_t          state, state_nxt;
  logic [DW-1:0]   ir;
  logic [2:0]      opc, fx, fy;
  logic            is_alu;

  logic            ir_in, rin_en, rout_en, rout_y;
  logic            din_out, g_out, a_in, g_in, done;
  logic [1:0]      alu_op;
  logic [NREG-1:0] r_in, r_out;

  assign opc = ir[OPC_MSB:OPC_LSB];
  assign fx  = ir[X_MSB:X_LSB];
  assign fy  = ir[Y_MSB:Y_LSB];

  always_comb begin
    case (opc)
      OP_ADD, OP_SUB: is_alu = 1'b1;
`ifdef SPU_CTRL_AND_EN
      OP_AND:         is_alu = 1'b1;
`else
      OP_AND:         is_alu = 1'b0;
`endif
      default:        is_alu = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0 && bus.RUN) ir <= bus.INSTR;
    end
  end

  always_comb begin
    state_nxt = state;
    ir_in     = 1'b0;
    rin_en    = 1'b0;
    rout_en   = 1'b0;
    rout_y    = 1'b0;
    din_out   = 1'b0;
    g_out     = 1'b0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    alu_op    = ALU_ADD;
    done      = 1'b0;
    case (state)
      T0: begin
        ir_in = bus.RUN;
        if (bus.RUN) state_nxt = T1;
      end
      T1: begin
        if (is_alu) begin
          rout_en   = 1'b1;
          a_in      = 1'b1;
          state_nxt = T2;
        end else begin
          done      = 1'b1;
          state_nxt = T0;
          case (opc)
            OP_MV: begin
              rout_en = 1'b1;
              rout_y  = 1'b1;
              rin_en  = 1'b1;
            end
            OP_MVI: begin
              din_out = 1'b1;
              rin_en  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      T2: begin
        rout_en   = 1'b1;
        rout_y    = 1'b1;
        g_in      = 1'b1;
        alu_op    = alu_op_of(opc);
        state_nxt = T3;
      end
      T3: begin
        g_out     = 1'b1;
        rin_en    = 1'b1;
        done      = 1'b1;
        state_nxt = T0;
      end
      default: state_nxt = T0;
    endcase
  end

  // Write enables always target X; the read select is Y for mv and T2,
  // X for the first ALU operand.
  DECODER3x8 u_dec_rin (
    .W  (fx),
    .EN (rin_en & RESETN),
    .Y  (r_in)
  );

  DECODER3x8 u_dec_rout (
    .W  (rout_y ? fy : fx),
    .EN (rout_en & RESETN),
    .Y  (r_out)
  );

  // Reset clears the state asynchronously, but T0 would still reflect RUN
  // on IR_IN, so every output is also gated by RESETN directly.
  assign bus.IR_IN   = ir_in & RESETN;
  assign bus.R_IN    = r_in;
  assign bus.R_OUT   = r_out;
  assign bus.DIN_OUT = din_out & RESETN;
  assign bus.G_OUT   = g_out & RESETN;
  assign bus.A_IN    = a_in & RESETN;
  assign bus.G_IN    = g_in & RESETN;
  assign bus.ALU_OP  = alu_op & {2{RESETN}};
  assign bus.DONE    = done & RESETN;
  assign bus.BUSY    = (state != T0) & RESETN;
  assign dbg_state   = state;

endmodule

// File: tb/tb_spu_ctrl_fsm.sv
module tb_spu_ctrl_fsm;
  import spu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  state_t dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spu_ctrl_fsm_if bus ();

  spu_ctrl_fsm dut (
    .CLK       (clk),
    .RESETN    (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  // Observed vector layout:
  // [24] IR_IN [23:16] R_IN [15:8] R_OUT [7] DIN_OUT [6] G_OUT [5] A_IN
  // [4] G_IN [3:2] ALU_OP [1] DONE [0] BUSY
  logic [24:0] exp_q[$];

  function automatic logic [24:0] mk(input logic ir_in, input logic [7:0] r_in,
                                     input logic [7:0] r_out, input logic din,
                                     input logic gout, input logic ain,
                                     input logic gin, input logic [1:0] alu,
                                     input logic done, input logic busy);
    mk = {ir_in, r_in, r_out, din, gout, ain, gin, alu, done, busy};
  endfunction

  function automatic logic [24:0] pack();
    pack = {bus.IR_IN, bus.R_IN, bus.R_OUT, bus.DIN_OUT, bus.G_OUT, bus.A_IN,
            bus.G_IN, bus.ALU_OP, bus.DONE, bus.BUSY};
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per-instruction list of the cycles following acceptance.
  function automatic void push_steps(input logic [8:0] instr);
    logic [2:0] op;
    logic [7:0] ohx, ohy;
    logic       alu_class;
    logic [1:0] code;
    op  = instr[8:6];
    ohx = 8'd1 << instr[5:3];
    ohy = 8'd1 << instr[2:0];
    alu_class = (op == 3'd2) || (op == 3'd3);
    code = (op == 3'd3) ? 2'd1 : 2'd0;
`ifdef SPU_CTRL_AND_EN
    if (op == 3'd4) begin
      alu_class = 1'b1;
      code = 2'd2;
    end
`endif
    if (op == 3'd0)
      exp_q.push_back(mk(0, ohx, ohy, 0, 0, 0, 0, 2'd0, 1, 1));
    else if (op == 3'd1)
      exp_q.push_back(mk(0, ohx, 8'd0, 1, 0, 0, 0, 2'd0, 1, 1));
    else if (alu_class) begin
      exp_q.push_back(mk(0, 8'd0, ohx, 0, 0, 1, 0, 2'd0, 0, 1));
      exp_q.push_back(mk(0, 8'd0, ohy, 0, 0, 0, 1, code, 0, 1));
      exp_q.push_back(mk(0, ohx, 8'd0, 0, 1, 0, 0, 2'd0, 1, 1));
    end else
      exp_q.push_back(mk(0, 8'd0, 8'd0, 0, 0, 0, 0, 2'd0, 1, 1));
  endfunction

  // Compare process: every negedge, outputs against the model.
  logic [24:0] exp_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_v = '0;
    end else if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
    end else begin
      exp_v = mk(bus.RUN, 8'd0, 8'd0, 0, 0, 0, 0, 2'd0, 0, 0);
      if (bus.RUN) push_steps(bus.INSTR);
    end
    check("cycle_outputs", {7'd0, pack()}, {7'd0, exp_v});
  end

  // ---------------- driver ----------------
  // Inputs change at posedge+1; outputs sampled at the following negedge.
  task automatic run_cycle(input logic run, input logic [8:0] instr,
                           output logic [24:0] obs);
    bus.RUN   = run;
    bus.INSTR = instr;
    @(negedge clk);
    obs = pack();
    @(posedge clk);
    #1;
  endtask

  logic [24:0] obs;
  logic [7:0]  ir_mask, done_mask;

  initial begin
    rst_n     = 1'b0;
    bus.RUN   = 1'b0;
    bus.INSTR = '0;
    repeat (2) @(posedge clk);
    #1;
    // RUN high while held in reset: outputs must stay 0.
    bus.RUN = 1'b1;
    #1;
    check("reset_outputs", {7'd0, pack()}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, {30'd0, T0});
    @(posedge clk);
    #1;
    bus.RUN = 1'b0;
    rst_n   = 1'b1;
    run_cycle(0, 9'd0, obs);

    // mvi R2
    run_cycle(1, 9'b001_010_000, obs);
    check("mvi_t0", {7'd0, obs}, {7'd0, mk(1, 8'd0, 8'd0, 0, 0, 0, 0, 2'd0, 0, 0)});
    run_cycle(0, 9'd0, obs);
    check("mvi_t1_rin", {24'd0, obs[23:16]}, 32'h04);
    check("mvi_t1_din", {31'd0, obs[7]}, 32'd1);
    check("mvi_t1_done", {31'd0, obs[1]}, 32'd1);
    run_cycle(0, 9'd0, obs);
    check("mvi_after_busy", {31'd0, obs[0]}, 32'd0);

    // mv R5,R3
    run_cycle(1, 9'b000_101_011, obs);
    run_cycle(0, 9'd0, obs);
    check("mv_t1", {7'd0, obs}, {7'd0, mk(0, 8'h20, 8'h08, 0, 0, 0, 0, 2'd0, 1, 1)});
    run_cycle(0, 9'd0, obs);

    // sub R1,R6
    run_cycle(1, 9'b011_001_110, obs);
    run_cycle(0, 9'd0, obs);
    check("sub_t1", {7'd0, obs}, {7'd0, mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 2'd0, 0, 1)});
    run_cycle(0, 9'd0, obs);
    check("sub_t2", {7'd0, obs}, {7'd0, mk(0, 8'h00, 8'h40, 0, 0, 0, 1, 2'd1, 0, 1)});
    run_cycle(0, 9'd0, obs);
    check("sub_t3", {7'd0, obs}, {7'd0, mk(0, 8'h02, 8'h00, 0, 1, 0, 0, 2'd0, 1, 1)});
    run_cycle(0, 9'd0, obs);

    // Back-to-back mvi, add, mv with RUN held high
    ir_mask   = '0;
    done_mask = '0;
    for (int i = 0; i < 8; i++) begin
      logic [8:0] ins;
      ins = 9'($urandom_range(0, 511));
      if (i == 0) ins = 9'b001_011_000;
      if (i == 2) ins = 9'b010_011_100;
      if (i == 6) ins = 9'b000_001_010;
      run_cycle(1, ins, obs);
      ir_mask[i]   = obs[24];
      done_mask[i] = obs[1];
    end
    check("b2b_ir_in", {24'd0, ir_mask}, 32'b0100_0101);
    check("b2b_done", {24'd0, done_mask}, 32'b1010_0010);
    run_cycle(0, 9'd0, obs);

    // Reset during T2 of an add
    run_cycle(1, 9'b010_010_111, obs);
    run_cycle(0, 9'd0, obs);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {7'd0, pack()}, 32'd0);
    check("rst_mid_state", {30'd0, dbg_state}, {30'd0, T0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 9'd0, obs);
      check("rst_after_rin", {24'd0, obs[23:16]}, 32'd0);
      check("rst_after_busy", {31'd0, obs[0]}, 32'd0);
    end

    // Opcode 100
    run_cycle(1, 9'b100_000_001, obs);
    run_cycle(0, 9'd0, obs);
`ifdef SPU_CTRL_AND_EN
    check("and_t1", {7'd0, obs}, {7'd0, mk(0, 8'h00, 8'h01, 0, 0, 1, 0, 2'd0, 0, 1)});
    run_cycle(0, 9'd0, obs);
    check("and_t2", {7'd0, obs}, {7'd0, mk(0, 8'h00, 8'h02, 0, 0, 0, 1, 2'd2, 0, 1)});
    run_cycle(0, 9'd0, obs);
    check("and_t3", {7'd0, obs}, {7'd0, mk(0, 8'h01, 8'h00, 0, 1, 0, 0, 2'd0, 1, 1)});
`else
    check("and_nop_t1", {7'd0, obs}, {7'd0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 1, 1)});
`endif
    run_cycle(0, 9'd0, obs);

    // Randomized traffic with occasional asynchronous reset pulses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      run_cycle(($urandom_range(0, 3) != 0), 9'($urandom_range(0, 511)), obs);
    end
    run_cycle(0, 9'd0, obs);
    run_cycle(0, 9'd0, obs);
    run_cycle(0, 9'd0, obs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spu_ctrl_fsm.md
Name: spu_ctrl_fsm

Overview:
Control sequencer for the simple processor unit. It fetches a 9-bit instruction (format III_XXX_YYY) and steps the datapath through T0..T3. Each step drives the one-hot register write enables, the one-hot register read selects, the bus source and the ALU controls. It sits between the instruction source (DIN) and the register file, accumulator A, result register G and the shared bus mux.

Parameters:
- DW, 9, instruction/data bus width; the opcode occupies INSTR[8:6].
- NREG, 8, number of general registers. Fixed by the 3-bit register fields; any other value is illegal.

Ports:
- CLK  in  1  rising-edge clock.
- RESETN  in  1  asynchronous active-low reset.
- RUN  in  1  start request, sampled in T0 only.
- INSTR  in  DW  instruction word; captured when IR_IN=1.
- IR_IN  out  1  instruction-register load strobe.
- R_IN  out  8  one-hot register write enables; bit k enables Rk.
- R_OUT  out  8  one-hot register-to-bus drive selects.
- DIN_OUT  out  1  DIN drives the bus.
- G_OUT  out  1  G drives the bus.
- A_IN  out  1  load A from the bus.
- G_IN  out  1  load G from the ALU.
- ALU_OP  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 reserved.
- DONE  out  1  last cycle of the current instruction.
- BUSY  out  1  high whenever state != T0.

Behaviour:
- State register: T0, T1, T2, T3. Internal ir[8:0]. Both are clocked by CLK and cleared asynchronously by RESETN=0 (state=T0, ir=0).
- Outputs are combinational from state, ir and RUN. While RESETN=0, every output is forced to 0.
- Opcodes: 000 mv Rx,Ry; 001 mvi Rx,#D; 010 add Rx,Ry; 011 sub Rx,Ry; 100 and (optional feature, see below); 101..111 nop.
- T0: IR_IN=RUN. If RUN=1, ir<=INSTR and go to T1; otherwise stay in T0. All other outputs are 0.
- T1, mv: R_OUT=onehot(Y), R_IN=onehot(X), DONE=1, then T0.
- T1, mvi: DIN_OUT=1, R_IN=onehot(X), DONE=1, then T0. The immediate is the DIN bus word in this cycle.
- T1, add/sub/and: R_OUT=onehot(X), A_IN=1, then T2.
- T1, nop: DONE=1, then T0. No enables or selects asserted.
- T2: R_OUT=onehot(Y), G_IN=1, ALU_OP per opcode, then T3.
- T3: G_OUT=1, R_IN=onehot(X), DONE=1, then T0.
- ALU_OP is 00 outside T2.
- Latency: mv/mvi/nop take 2 cycles (T0, T1); ALU ops take 4 cycles (T0..T3).
- Back-to-back issue: with RUN held high, the cycle after DONE is T0 with IR_IN=1. There are no dead cycles.
- Invariant: at most one bus source (any R_OUT bit, DIN_OUT, G_OUT) is active per cycle. R_IN and R_OUT are each zero or one-hot.
- X==Y (e.g. mv R3,R3 or add R2,R2): legal. R_IN and R_OUT may select the same register in the same cycle.
- RUN is ignored outside T0. Deasserting RUN mid-instruction does not abort it.
- RESETN falling mid-instruction: outputs drop to 0 immediately and state returns to T0. There is no partial writeback after reset release.
- INSTR is don't-care except in T0 when RUN=1.

Optional Feature:
- Macro SPU_CTRL_AND_EN.
- Defined: opcode 100 runs the ALU sequence with ALU_OP=10 in T2.
- Undefined: opcode 100 decodes as nop (2 cycles, DONE in T1), and ALU_OP never takes the value 10.

Decomposition:
- Package spu_pkg holds:
  - opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND;
  - the state enum (T0..T3);
  - ALU_OP codes;
  - INSTR field slice positions.
- Sub-module: reuse the existing 3-to-8 enable decoder (DECODER3x8), instantiated twice. One instance decodes the X field into R_IN, the other decodes the X/Y mux into R_OUT. Each instance's EN is driven from state/opcode gating.

Test Plan:
- Reset, then RUN=1 with INSTR=001_010_000 (mvi R2): T1 shows DIN_OUT=1, R_IN=8'b00000100, DONE=1; total 2 cycles; BUSY high for 1 cycle.
- INSTR=000_101_011 (mv R5,R3): T1 shows R_OUT=8'b00001000, R_IN=8'b00100000, DONE=1; no other strobes.
- INSTR=011_001_110 (sub R1,R6):
  - T1: R_OUT=8'b00000010 with A_IN=1;
  - T2: R_OUT=8'b01000000 with G_IN=1 and ALU_OP=01;
  - T3: G_OUT=1, R_IN=8'b00000010, DONE=1.
- RUN held high across mvi, add, mv: IR_IN pulses exactly on cycles 0, 2 and 6; DONE on cycles 1, 5 and 7.
- Assert RESETN=0 during T2 of an add: all outputs 0 asynchronously; after release, state is T0 and no R_IN pulse occurs until a new RUN.
- INSTR=100_000_001:
  - with SPU_CTRL_AND_EN: 4-cycle sequence with ALU_OP=10 in T2;
  - without it: DONE in T1 and all enables 0.
